// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register file and sequencer for a multi-cycle multiplier/divider.
module hilo_ctrl #(
    parameter int MULT_LAT = 33,
    parameter int DIV_LAT  = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    input  logic        div_zero,
    output logic        md_run,
    output logic        md_sel,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz_flag
);
    typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;
    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d, rd_valid_q, rd_valid_d, dz_q, dz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, rd_data_q, rd_data_d;
    logic        req_any;
    assign req_any = mult_start | div_start | mfhi | mflo | mthi | mtlo;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        dz_d       = dz_q;
        case (state_q)
            IDLE: begin
                // read samples the old registers, so same-cycle writes are not visible
                if (mfhi | mflo) begin
                    rd_data_d  = mfhi ? hi_q : lo_q;
                    rd_valid_d = 1'b1;
                end
                if (mthi) hi_d = wr_data;
                if (mtlo) lo_d = wr_data;
                if (mult_start | div_start) begin
                    state_d = RUN;
                    sel_d   = ~mult_start;
                    cnt_d   = mult_start ? 6'(MULT_LAT - 1) : 6'(DIV_LAT - 1);
                    dz_d    = 1'b0;
                end
            end
            RUN: begin
                state_d = (cnt_q == 6'd0) ? CAPTURE : RUN;
                cnt_d   = (cnt_q == 6'd0) ? cnt_q : cnt_q - 6'd1;
            end
            CAPTURE: begin
                state_d = IDLE;
                if (sel_q && div_zero) begin
                    dz_d = 1'b1;
                end else begin
                    hi_d = md_hi;
                    lo_d = md_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            sel_q      <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            dz_q       <= dz_d;
        end
    end
    assign md_run   = (state_q == RUN);
    assign md_sel   = sel_q;
    assign busy     = (state_q != IDLE);
    assign stall    = ~reset & (busy ? req_any : (mfhi & mflo));
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign dz_flag  = dz_q;
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed and random stimulus checked against a transaction-level HI/LO model.
module tb_hilo_ctrl;
    localparam int MULT_LAT = 33;
    localparam int DIV_LAT  = 33;
    logic        clk = 1'b0;
    logic        rst, ms, ds, fh, fl, th, tl, dzr;
    logic [31:0] wd, mh, ml;
    logic        md_run, md_sel, busy, stall, rd_valid, dz_flag;
    logic [31:0] rd_data, hi, lo;
    int n_chk = 0, n_err = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_rdd = 0;
    logic        m_dz = 0, m_sel = 0, m_rdv = 0, m_stall = 0;
    int          m_left = 0;

    hilo_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clk), .reset(rst), .mult_start(ms), .div_start(ds),
        .mfhi(fh), .mflo(fl), .mthi(th), .mtlo(tl), .wr_data(wd),
        .md_hi(mh), .md_lo(ml), .div_zero(dzr), .md_run(md_run),
        .md_sel(md_sel), .busy(busy), .stall(stall), .rd_data(rd_data),
        .rd_valid(rd_valid), .hi(hi), .lo(lo), .dz_flag(dz_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        {rst, ms, ds, fh, fl, th, tl} = '0;
    endtask

    // m_left counts the busy cycles still to come; the last one is the capture cycle
    task automatic cyc();
        logic any;
        @(negedge clk);
        #1;
        any = ms | ds | fh | fl | th | tl;
        m_stall = !rst && ((m_left > 0) ? any : (fh & fl));
        chk("stall", stall, m_stall);
        chk("busy", busy, m_left > 0);
        chk("md_run", md_run, m_left > 1);
        chk("md_sel", md_sel, m_sel);
        @(posedge clk);
        if (rst) begin
            {m_hi, m_lo, m_rdd} = '0;
            {m_dz, m_sel, m_rdv} = '0;
            m_left = 0;
        end else begin
            m_rdv = 1'b0;
            if (m_left == 0) begin
                if (fh | fl) begin
                    m_rdd = fh ? m_hi : m_lo;
                    m_rdv = 1'b1;
                end
                if (th) m_hi = wd;
                if (tl) m_lo = wd;
                if (ms | ds) begin
                    m_sel  = !ms;
                    m_dz   = 1'b0;
                    m_left = (ms ? MULT_LAT : DIV_LAT) + 1;
                end
            end else begin
                if (m_left == 1) begin
                    if (m_sel && dzr) m_dz = 1'b1;
                    else begin
                        m_hi = mh;
                        m_lo = ml;
                    end
                end
                m_left--;
            end
        end
        #1;
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("dz_flag", dz_flag, m_dz);
        chk("rd_valid", rd_valid, m_rdv);
        chk("rd_data", rd_data, m_rdd);
    endtask

    initial begin
        clr();
        wd = 0; mh = 0; ml = 0; dzr = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        cyc();
        clr(); cyc();
        // same-cycle read/write hazard
        th = 1; wd = 7; cyc();
        clr(); th = 1; fh = 1; wd = 9; cyc();
        clr(); cyc();
        chk("hazard_rd", rd_data, 32'd7);
        chk("hazard_hi", hi, 32'd9);
        // multiply path
        mh = 32'h00000001; ml = 32'hFFFFFFFE;
        ms = 1; cyc();
        clr(); repeat (MULT_LAT + 2) cyc();
        chk("mult_hi", hi, 32'h00000001);
        chk("mult_lo", lo, 32'hFFFFFFFE);
        // divide by zero keeps hi and sets the sticky flag
        th = 1; wd = 32'hAAAA0000; cyc();
        clr(); ds = 1; dzr = 1; mh = 32'h1234; cyc();
        clr(); repeat (DIV_LAT + 2) cyc();
        chk("dz_hi", hi, 32'hAAAA0000);
        chk("dz_set", dz_flag, 1'b1);
        ms = 1; cyc();
        clr(); cyc();
        chk("dz_clr", dz_flag, 1'b0);
        // held mflo stalls until the multiply finishes
        dzr = 0; ml = 32'h5555AAAA;
        repeat (4) cyc();
        fl = 1;
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (!m_stall) break;
        end
        chk("held_mflo_stall_bound", m_stall, 1'b0);
        clr(); cyc();
        chk("held_mflo_data", rd_data, 32'h5555AAAA);
        // start priority and read priority
        ms = 1; ds = 1; cyc();
        clr(); cyc();
        chk("prio_sel", md_sel, 1'b0);
        repeat (MULT_LAT + 1) cyc();
        fh = 1; fl = 1; cyc();
        clr(); cyc();
        // reset mid-run abandons the operation
        mh = 32'hDEAD; ml = 32'hBEEF;
        ms = 1; cyc();
        clr(); repeat (10) cyc();
        rst = 1; cyc();
        clr(); repeat (MULT_LAT + 3) cyc();
        chk("rst_abandon_hi", hi, 32'd0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            ms  = ($urandom_range(0, 15) == 0);
            ds  = ($urandom_range(0, 15) == 0);
            fh  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 3) == 0);
            th  = ($urandom_range(0, 3) == 0);
            tl  = ($urandom_range(0, 3) == 0);
            dzr = $urandom_range(0, 1) == 1;
            wd  = $urandom;
            mh  = $urandom;
            ml  = $urandom;
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 33, number of cycles md_run stays high for a multiply before the result is captured.
REQ-002 Parameter DIV_LAT, default 33, number of cycles md_run stays high for a divide before the result is captured.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mult_start  input  1  request a multiply of the operands currently presented to the arithmetic unit.
REQ-006 div_start  input  1  request a divide.
REQ-007 mfhi / mflo  input  1 each  read request for HI / LO.
REQ-008 mthi / mtlo  input  1 each  write request for HI / LO.
REQ-009 wr_data  input  32  data for mthi/mtlo.
REQ-010 md_hi / md_lo  input  32 each  result from the multiplier/divider.
REQ-011 div_zero  input  1  divider flag: divisor is zero, sampled at capture.
REQ-012 md_run  output  1  run/enable to the multiplier/divider.
REQ-013 md_sel  output  1  0 = multiply, 1 = divide; held stable while md_run=1.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 stall  output  1  combinational; high when the current request cannot be accepted this cycle.
REQ-016 rd_data  output  32  registered read data.
REQ-017 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-018 hi / lo  output  32 each  current architectural HI and LO.
REQ-019 dz_flag  output  1  sticky divide-by-zero indicator.

Function
REQ-020 FSM states SHALL be IDLE, RUN and CAPTURE, with a 6-bit down-counter cnt.
REQ-021 IDLE with mult_start=1 SHALL go to RUN with md_sel=0 and cnt=MULT_LAT-1; mult_start has priority over a simultaneous div_start.
REQ-022 IDLE with div_start=1 (and mult_start=0) SHALL go to RUN with md_sel=1 and cnt=DIV_LAT-1.
REQ-023 An accepted start SHALL clear dz_flag.
REQ-024 RUN SHALL hold md_run=1 and decrement cnt each cycle; cnt==0 moves to CAPTURE.
REQ-025 md_run SHALL be high for exactly MULT_LAT or DIV_LAT cycles.
REQ-026 CAPTURE SHALL drive md_run=0 and load hi<=md_hi, lo<=md_lo, then go to IDLE.
REQ-027 If md_sel=1 and div_zero=1 in CAPTURE, hi/lo SHALL stay unchanged and dz_flag SHALL be set.
REQ-028 Start latency: the first md_run=1 cycle SHALL be the cycle after the start is accepted; hi/lo SHALL update at the end of the CAPTURE cycle.
REQ-029 A start, mfhi, mflo, mthi or mtlo asserted while busy=1 SHALL raise stall in that cycle and SHALL NOT be acted upon; the requester holds it until stall=0.
REQ-030 mfhi in IDLE SHALL give rd_data=hi and rd_valid=1 on the next cycle; mflo likewise with lo.
REQ-031 Simultaneous mfhi and mflo SHALL service mfhi only and assert stall for that cycle.
REQ-032 mthi/mtlo in IDLE SHALL write wr_data into hi/lo at that edge; both asserted SHALL write both.
REQ-033 A read and a write to the same register in the same IDLE cycle SHALL return the old value.
REQ-034 A write and a start in the same IDLE cycle SHALL both be accepted; the later capture overwrites the written value.
REQ-035 A read and a start in the same IDLE cycle SHALL both be accepted; the read returns the pre-operation value.
REQ-036 rd_valid SHALL be 0 in every cycle not following an accepted read; rd_data SHALL hold its last value.

Reset
REQ-037 reset=1 at a rising edge SHALL force state=IDLE, cnt=0, md_run=0, md_sel=0, hi=0, lo=0, rd_data=0, rd_valid=0 and dz_flag=0.
REQ-038 Reset SHALL take priority over every request, including mid-RUN; an in-flight operation SHALL be abandoned and never captured.
REQ-039 stall SHALL be 0 while reset=1.

Verification
REQ-040 Multiply path: mult_start in IDLE, md_hi=32'h00000001, md_lo=32'hFFFFFFFE -> md_run high for 33 cycles with md_sel=0, then hi/lo equal those values and busy=0.
REQ-041 Divide by zero: mthi 32'hAAAA0000, then div_start with div_zero=1 at capture -> hi stays 32'hAAAA0000 and dz_flag=1; next mult_start -> dz_flag=0.
REQ-042 Stall: mflo at cycle 5 of a multiply -> stall=1 and no rd_valid until capture; the held mflo then gives the new lo with rd_valid=1 one cycle after acceptance.
REQ-043 Priority: mult_start and div_start together -> md_sel=0; mfhi and mflo together -> only hi is returned and stall=1 for that cycle.
REQ-044 Reset mid-operation: reset at cycle 10 of RUN -> next cycle md_run=0, hi=lo=0, busy=0; no later capture.
REQ-045 Same-cycle hazard: hi=7, then mthi with wr_data=9 and mfhi together -> rd_data=7, then hi=9.
